prio_resource_arbiter: RTL and testbench

- Sequential, parametrised successor of the two-user function/priority arbiter.
- N_CH user channels request one of N_FUN shared functions. Each channel carries a priority profile.
- The block holds ownership across cycles, resolves simultaneous and occupied-resource conflicts by profile, breaks ties round-robin, and optionally preempts.
- It sits between the switch/button input stage and the LED/matrix/7-segment display decoders.

---
 rtl/arb_pkg.sv | 25 ++
 rtl/arb_fun_slot.sv | 135 +++++++++++++
 rtl/prio_resource_arbiter.sv | 159 +++++++++++++++
 tb/tb_prio_resource_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and width helpers for the priority resource arbiter.
// Widths never drop below 1 bit so degenerate parameter choices stay legal.
package arb_pkg;

  typedef enum logic [1:0] {
    S_FREE  = 2'd0,
    S_OWNED = 2'd1,
    S_GUARD = 2'd2
  } slot_state_t;

  localparam int PROF_INVALID = 0;

  function automatic int fun_w(input int n_fun);
    return (n_fun > 2) ? $clog2(n_fun) : 1;
  endfunction

  function automatic int ch_w(input int n_ch);
    return (n_ch > 2) ? $clog2(n_ch) : 1;
  endfunction

  function automatic int tmr_w(input int hold);
    return (hold > 0) ? $clog2(hold + 1) : 1;
  endfunction

endpackage

// File: rtl/arb_fun_slot.sv
// One shared function: FREE/OWNED/GUARD ownership FSM, hold timer,
// round-robin tie pointer and profile-based winner selection.
module arb_fun_slot
  import arb_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int PRIO_W      = 2,
  parameter int HOLD_CYCLES = 0,
  parameter int PREEMPT     = 1,
  parameter int CW          = 1,
  parameter int TW          = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH*PRIO_W-1:0]   prof_i,
  input  logic [N_CH-1:0]          req_i,
  input  logic [N_CH-1:0]          rel_i,
  output logic [CW-1:0]            owner_o,
  output logic                     owned_o,
  output logic                     busy_o,
  output logic                     deny_o,
  output logic                     win_o,
  output logic [PRIO_W-1:0]        win_prof_o
);

  slot_state_t       r_state, w_state_next;
  logic [CW-1:0]     r_owner, w_owner_next;
  logic [CW-1:0]     r_rr, w_rr_next;
  logic [TW-1:0]     r_timer, w_timer_next;
  logic [CW-1:0]     w_win;
  logic [PRIO_W-1:0] w_win_prof, w_own_prof;
  logic              w_found, w_multi, w_own_rel, w_release;
  int                w_cnt, w_dist, w_best_dist;

  // Highest profile wins; among equals the smallest distance from r_rr wins.
  always_comb begin
    w_found     = 1'b0;
    w_win       = '0;
    w_win_prof  = '0;
    w_cnt       = 0;
    w_dist      = 0;
    w_best_dist = 0;
    for (int c = 0; c < N_CH; c++) begin
      if (req_i[c]) begin
        w_cnt  = w_cnt + 1;
        w_dist = (c >= int'(r_rr)) ? (c - int'(r_rr)) : (c + N_CH - int'(r_rr));
        if (!w_found || (prof_i[c*PRIO_W +: PRIO_W] > w_win_prof) ||
            ((prof_i[c*PRIO_W +: PRIO_W] == w_win_prof) && (w_dist < w_best_dist))) begin
          w_found     = 1'b1;
          w_win       = CW'(c);
          w_win_prof  = prof_i[c*PRIO_W +: PRIO_W];
          w_best_dist = w_dist;
        end
      end
    end
    w_multi = (w_cnt > 1);
  end

  always_comb begin
    w_own_prof = '0;
    w_own_rel  = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (r_owner == CW'(c)) begin
        w_own_prof = prof_i[c*PRIO_W +: PRIO_W];
        w_own_rel  = rel_i[c];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_rr_next    = r_rr;
    w_timer_next = r_timer;
    w_release    = 1'b0;
    deny_o       = 1'b0;
    win_o        = 1'b0;
    case (r_state)
      S_FREE: begin
        if (w_found) begin
          w_state_next = S_OWNED;
          w_owner_next = w_win;
          w_timer_next = TW'(HOLD_CYCLES);
          w_rr_next    = (int'(w_win) == N_CH - 1) ? '0 : w_win + CW'(1);
          deny_o       = w_multi;
          win_o        = 1'b1;
        end
      end
      S_OWNED: begin
        if (r_timer != '0) w_timer_next = r_timer - TW'(1);
        // Timer value 1 means this edge is the last owned cycle.
        w_release = w_own_rel || (int'(w_own_prof) == PROF_INVALID) ||
                    ((HOLD_CYCLES > 0) && (r_timer <= TW'(1)));
        if (w_release) begin
          w_state_next = S_GUARD;
          w_owner_next = '0;
          w_timer_next = '0;
          deny_o       = w_found;
        end else if (w_found) begin
          if ((PREEMPT != 0) && (w_win_prof > w_own_prof)) begin
            w_owner_next = w_win;
            w_timer_next = TW'(HOLD_CYCLES);
            win_o        = 1'b1;
          end
          deny_o = 1'b1;
        end
      end
      S_GUARD: begin
        w_state_next = S_FREE;
        deny_o       = w_found;
      end
      default: w_state_next = S_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FREE;
      r_owner <= '0;
      r_rr    <= '0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
      r_rr    <= w_rr_next;
      r_timer <= w_timer_next;
    end
  end

  assign owned_o    = (r_state == S_OWNED);
  assign busy_o     = (r_state != S_FREE);
  assign owner_o    = (r_state == S_OWNED) ? r_owner : '0;
  assign win_prof_o = w_win_prof;

endmodule

// File: rtl/prio_resource_arbiter.sv
// Multi-channel function arbiter: button conditioning, request filtering,
// one ownership slot per function, conflict pulse and display profile.
module prio_resource_arbiter
  import arb_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int N_FUN       = 3,
  parameter int PRIO_W      = 2,
  parameter int HOLD_CYCLES = 0,
  parameter int PREEMPT     = 1,
  localparam int FW         = fun_w(N_FUN),
  localparam int CW         = ch_w(N_CH),
  localparam int TW         = tmr_w(HOLD_CYCLES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH*PRIO_W-1:0]  prof_i,
  input  logic [N_CH*FW-1:0]      fun_sel_i,
  input  logic [N_CH-1:0]         req_i,
  input  logic [N_CH-1:0]         rel_i,
  output logic [N_CH*N_FUN-1:0]   grant_o,
  output logic [N_FUN-1:0]        busy_o,
  output logic [N_FUN*CW-1:0]     owner_o,
  output logic                    conflict_o,
  output logic                    prof_err_o,
  output logic [PRIO_W-1:0]       disp_prof_o
);

  logic r_rst_s1, r_rst_s2, w_rst_n;
  logic [N_CH-1:0] r_req_s1, r_req_s2, r_req_s3;
  logic [N_CH-1:0] r_rel_s1, r_rel_s2, r_rel_s3;
  logic [N_CH-1:0] w_req_evt, w_rel_evt, w_owns, w_req_ok;
  logic [N_FUN-1:0][CW-1:0]     w_owner;
  logic [N_FUN-1:0][PRIO_W-1:0] w_win_prof;
  logic [N_FUN-1:0] w_owned, w_deny, w_win;
  logic             r_conflict;
  logic [PRIO_W-1:0] r_disp, w_disp_next;

  // Reset asserts immediately and releases two edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_s1 <= 1'b0;
      r_rst_s2 <= 1'b0;
    end else begin
      r_rst_s1 <= 1'b1;
      r_rst_s2 <= r_rst_s1;
    end
  end
  assign w_rst_n = r_rst_s2;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_req_s1 <= '0;
      r_req_s2 <= '0;
      r_req_s3 <= '0;
      r_rel_s1 <= '0;
      r_rel_s2 <= '0;
      r_rel_s3 <= '0;
    end else begin
      r_req_s1 <= req_i;
      r_req_s2 <= r_req_s1;
      r_req_s3 <= r_req_s2;
      r_rel_s1 <= rel_i;
      r_rel_s2 <= r_rel_s1;
      r_rel_s3 <= r_rel_s2;
    end
  end
  assign w_req_evt = r_req_s2 & ~r_req_s3;
  assign w_rel_evt = r_rel_s2 & ~r_rel_s3;

  always_comb begin
    w_owns = '0;
    for (int f = 0; f < N_FUN; f++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (w_owned[f] && (w_owner[f] == CW'(c))) w_owns[c] = 1'b1;
      end
    end
  end

  // A release from the same channel in the same cycle cancels its request.
  always_comb begin
    w_req_ok = '0;
    for (int c = 0; c < N_CH; c++) begin
      w_req_ok[c] = w_req_evt[c] && !w_rel_evt[c] && !w_owns[c] &&
                    (int'(prof_i[c*PRIO_W +: PRIO_W]) != PROF_INVALID) &&
                    (int'(fun_sel_i[c*FW +: FW]) < N_FUN);
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < N_FUN; gi++) begin : g_slot
      logic [N_CH-1:0] w_sreq;

      always_comb begin
        w_sreq = '0;
        for (int c = 0; c < N_CH; c++) begin
          w_sreq[c] = w_req_ok[c] && (int'(fun_sel_i[c*FW +: FW]) == gi);
        end
      end

      arb_fun_slot #(
        .N_CH        (N_CH),
        .PRIO_W      (PRIO_W),
        .HOLD_CYCLES (HOLD_CYCLES),
        .PREEMPT     (PREEMPT),
        .CW          (CW),
        .TW          (TW)
      ) u_slot (
        .clk        (clk),
        .rst_n      (w_rst_n),
        .prof_i     (prof_i),
        .req_i      (w_sreq),
        .rel_i      (w_rel_evt),
        .owner_o    (w_owner[gi]),
        .owned_o    (w_owned[gi]),
        .busy_o     (busy_o[gi]),
        .deny_o     (w_deny[gi]),
        .win_o      (w_win[gi]),
        .win_prof_o (w_win_prof[gi])
      );

      assign owner_o[gi*CW +: CW] = w_owner[gi];

      for (gj = 0; gj < N_CH; gj++) begin : g_grant
        assign grant_o[gj*N_FUN + gi] = w_owned[gi] && (w_owner[gi] == CW'(gj));
      end
    end
  endgenerate

  // With several grants in one cycle the lowest function index is displayed.
  always_comb begin
    w_disp_next = r_disp;
    for (int f = N_FUN - 1; f >= 0; f--) begin
      if (w_win[f]) w_disp_next = w_win_prof[f];
    end
  end

  always_comb begin
    prof_err_o = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      if (int'(prof_i[c*PRIO_W +: PRIO_W]) != PROF_INVALID) prof_err_o = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_conflict <= 1'b0;
      r_disp     <= '0;
    end else begin
      r_conflict <= |w_deny;
      r_disp     <= w_disp_next;
    end
  end

  assign conflict_o  = r_conflict;
  assign disp_prof_o = r_disp;

endmodule

// File: tb/tb_prio_resource_arbiter.sv
// Two arbiters (no timeout + preempt, 5-cycle timeout + no preempt) share one
// stimulus stream; a rule-level model predicts every output after every edge.
module tb_prio_resource_arbiter;

  localparam int NC = 2;
  localparam int NF = 3;
  localparam int PW = 2;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NC*PW-1:0]  prof;
  logic [NC*SW-1:0]  sel;
  logic [NC-1:0]     req, rel;

  logic [NC*NF-1:0]  grant_w [2];
  logic [NF-1:0]     busy_w  [2];
  logic [NF-1:0]     owner_w [2];
  logic              conf_w  [2];
  logic              perr_w  [2];
  logic [PW-1:0]     disp_w  [2];

  prio_resource_arbiter #(
    .N_CH(NC), .N_FUN(NF), .PRIO_W(PW), .HOLD_CYCLES(0), .PREEMPT(1)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .prof_i(prof), .fun_sel_i(sel), .req_i(req), .rel_i(rel),
    .grant_o(grant_w[0]), .busy_o(busy_w[0]), .owner_o(owner_w[0]),
    .conflict_o(conf_w[0]), .prof_err_o(perr_w[0]), .disp_prof_o(disp_w[0])
  );

  prio_resource_arbiter #(
    .N_CH(NC), .N_FUN(NF), .PRIO_W(PW), .HOLD_CYCLES(5), .PREEMPT(0)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .prof_i(prof), .fun_sel_i(sel), .req_i(req), .rel_i(rel),
    .grant_o(grant_w[1]), .busy_o(busy_w[1]), .owner_o(owner_w[1]),
    .conflict_o(conf_w[1]), .prof_err_o(perr_w[1]), .disp_prof_o(disp_w[1])
  );

  int HOLDV [2] = '{0, 5};
  int PREV  [2] = '{1, 0};

  // Model: st 0=free 1=owned 2=guard; gt = edge number of the latest grant.
  int m_st [2][NF];
  int m_own[2][NF];
  int m_rr [2][NF];
  int m_gt [2][NF];
  int m_disp[2];
  bit m_conf[2];
  logic [NC-1:0] hr [3];
  logic [NC-1:0] hl [3];
  int cyc, rst_cnt;
  int total, bad;

  function automatic int pr(input int c);
    return int'(prof[c*PW +: PW]);
  endfunction

  function automatic int sl(input int c);
    return int'(sel[c*SW +: SW]);
  endfunction

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, inst, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      for (int f = 0; f < NF; f++) begin
        m_st[i][f] = 0; m_own[i][f] = 0; m_rr[i][f] = 0; m_gt[i][f] = 0;
      end
      m_disp[i] = 0;
      m_conf[i] = 0;
    end
    for (int k = 0; k < 3; k++) begin
      hr[k] = '0;
      hl[k] = '0;
    end
  endtask

  task automatic model_inst(input int i, input logic [NC-1:0] evr, input logic [NC-1:0] evl);
    bit owns[NC];
    bit valid[NC];
    bit got;
    int nreq, maxp, win, c;
    bit rls;
    for (int k = 0; k < NC; k++) owns[k] = 0;
    for (int f = 0; f < NF; f++) if (m_st[i][f] == 1) owns[m_own[i][f]] = 1;
    for (int k = 0; k < NC; k++)
      valid[k] = evr[k] && !evl[k] && pr(k) != 0 && sl(k) < NF && !owns[k];
    m_conf[i] = 0;
    got = 0;
    for (int f = 0; f < NF; f++) begin
      nreq = 0; maxp = -1; win = -1;
      for (int k = 0; k < NC; k++)
        if (valid[k] && sl(k) == f) begin
          nreq++;
          if (pr(k) > maxp) maxp = pr(k);
        end
      for (int k = 0; k < NC; k++) begin
        c = (m_rr[i][f] + k) % NC;
        if (win < 0 && valid[c] && sl(c) == f && pr(c) == maxp) win = c;
      end
      case (m_st[i][f])
        0: if (nreq > 0) begin
          m_st[i][f] = 1; m_own[i][f] = win; m_gt[i][f] = cyc;
          m_rr[i][f] = (win + 1) % NC;
          if (nreq > 1) m_conf[i] = 1;
          if (!got) begin m_disp[i] = pr(win); got = 1; end
        end
        1: begin
          rls = evl[m_own[i][f]] || pr(m_own[i][f]) == 0 ||
                (HOLDV[i] > 0 && cyc - m_gt[i][f] >= HOLDV[i]);
          if (rls) begin
            m_st[i][f] = 2;
            if (nreq > 0) m_conf[i] = 1;
          end else if (nreq > 0) begin
            m_conf[i] = 1;
            if (PREV[i] != 0 && pr(win) > pr(m_own[i][f])) begin
              m_own[i][f] = win; m_gt[i][f] = cyc;
              if (!got) begin m_disp[i] = pr(win); got = 1; end
            end
          end
        end
        default: begin
          m_st[i][f] = 0;
          if (nreq > 0) m_conf[i] = 1;
        end
      endcase
    end
  endtask

  task automatic model_update();
    logic [NC-1:0] evr, evl;
    cyc++;
    if (!rst_n || rst_cnt < 2) begin
      model_clear();
      if (!rst_n) rst_cnt = 0; else rst_cnt++;
      return;
    end
    evr = hr[1] & ~hr[2];
    evl = hl[1] & ~hl[2];
    hr[2] = hr[1]; hr[1] = hr[0]; hr[0] = req;
    hl[2] = hl[1]; hl[1] = hl[0]; hl[0] = rel;
    for (int i = 0; i < 2; i++) model_inst(i, evr, evl);
  endtask

  task automatic check_all();
    logic [NC*NF-1:0] eg;
    logic [NF-1:0] eb, eo;
    for (int i = 0; i < 2; i++) begin
      eg = '0; eb = '0; eo = '0;
      for (int f = 0; f < NF; f++) begin
        if (m_st[i][f] == 1) begin
          eg[m_own[i][f]*NF + f] = 1'b1;
          eo[f] = (m_own[i][f] != 0);
        end
        eb[f] = (m_st[i][f] != 0);
      end
      chk("grant", i, 32'(grant_w[i]), 32'(eg));
      chk("busy", i, 32'(busy_w[i]), 32'(eb));
      chk("owner", i, 32'(owner_w[i]), 32'(eo));
      chk("conflict", i, 32'(conf_w[i]), 32'(m_conf[i]));
      chk("disp", i, 32'(disp_w[i]), 32'(m_disp[i]));
      chk("prof_err", i, 32'(perr_w[i]), 32'(prof == '0));
      for (int c = 0; c < NC; c++)
        chk("one_per_ch", i, 32'($countones(grant_w[i][c*NF +: NF]) <= 1), 32'd1);
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_update();
      #1;
      check_all();
    end
  endtask

  task automatic set_ch(input int c, input int p, input int s);
    prof[c*PW +: PW] = PW'(p);
    sel[c*SW +: SW]  = SW'(s);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; rst_cnt = 0;
    rst_n = 1'b0; prof = '0; sel = '0; req = '0; rel = '0;
    set_ch(0, 2, 0); set_ch(1, 1, 0);
    model_clear();
    steps(3);
    rst_n = 1'b1;
    steps(4);
    chk("rst_grant", 0, 32'(grant_w[0]), 32'd0);
    chk("rst_disp", 0, 32'(disp_w[0]), 32'd0);

    // basic grant, release and guard
    set_ch(0, 2, 1);
    req[0] = 1'b1; steps(3);
    chk("basic_grant", 0, 32'(grant_w[0]), 32'b000010);
    chk("basic_disp", 0, 32'(disp_w[0]), 32'd2);
    req[0] = 1'b0; steps(1);
    rel[0] = 1'b1; steps(3);
    chk("guard_busy", 0, 32'(busy_w[0]), 32'b010);
    chk("guard_grant", 0, 32'(grant_w[0]), 32'd0);
    steps(1);
    chk("free_busy", 0, 32'(busy_w[0]), 32'd0);
    rel[0] = 1'b0; steps(4);

    // simultaneous requests, unequal then equal profiles
    set_ch(0, 1, 0); set_ch(1, 3, 0);
    req = 2'b11; steps(3);
    chk("sim_grant", 0, 32'(grant_w[0]), 32'b001000);
    chk("sim_conflict", 0, 32'(conf_w[0]), 32'd1);
    req = 2'b00; steps(1);
    chk("sim_pulse_end", 0, 32'(conf_w[0]), 32'd0);
    rel[1] = 1'b1; steps(3); rel = '0; steps(3);
    set_ch(0, 2, 0); set_ch(1, 2, 0);
    req = 2'b11; steps(3);
    chk("rr_first", 0, 32'(grant_w[0]), 32'b000001);
    req = 2'b00; steps(1);
    rel[0] = 1'b1; steps(3); rel = '0; steps(3);
    req = 2'b11; steps(3);
    chk("rr_second", 0, 32'(grant_w[0]), 32'b001000);
    req = 2'b00; steps(1);
    rel[1] = 1'b1; steps(3); rel = '0; steps(3);

    // preemption versus no preemption
    set_ch(0, 1, 2); set_ch(1, 2, 2);
    req[0] = 1'b1; steps(3);
    req[0] = 1'b0; req[1] = 1'b1; steps(3);
    chk("preempt_owner", 0, 32'(owner_w[0]), 32'b100);
    chk("preempt_grant", 0, 32'(grant_w[0]), 32'b100000);
    chk("preempt_conflict", 0, 32'(conf_w[0]), 32'd1);
    chk("nopreempt_grant", 1, 32'(grant_w[1]), 32'b000100);
    chk("nopreempt_owner", 1, 32'(owner_w[1]), 32'd0);
    chk("nopreempt_conflict", 1, 32'(conf_w[1]), 32'd1);
    req[1] = 1'b0;
    rel[1] = 1'b1; steps(3); rel = '0; steps(3);

    // timeout on the 5-cycle instance
    set_ch(0, 2, 1);
    req[0] = 1'b1; steps(3);
    req[0] = 1'b0; steps(4);
    chk("hold_still", 1, 32'(grant_w[1]), 32'b000010);
    steps(1);
    chk("timeout_grant", 1, 32'(grant_w[1]), 32'd0);
    chk("timeout_busy", 1, 32'(busy_w[1]), 32'b010);
    steps(1);
    chk("timeout_free", 1, 32'(busy_w[1]), 32'd0);

    // profile drop while owning
    set_ch(1, 2, 0);
    req[1] = 1'b1; steps(3);
    chk("drop_pre", 0, 32'(grant_w[0]), 32'b001010);
    req[1] = 1'b0; steps(1);
    set_ch(1, 0, 0); steps(1);
    chk("drop_busy", 0, 32'(busy_w[0]), 32'b011);
    chk("drop_grant", 0, 32'(grant_w[0]), 32'b000010);
    steps(1);
    chk("drop_free", 0, 32'(busy_w[0]), 32'b010);

    // all profiles invalid
    set_ch(0, 0, 1); #1;
    chk("prof_err", 0, 32'(perr_w[0]), 32'd1);
    req = 2'b11; steps(4);
    chk("perr_nogrant", 0, 32'(grant_w[0]), 32'd0);
    chk("perr_noconf", 0, 32'(conf_w[0]), 32'd0);
    req = 2'b00; steps(2);

    // invalid requests: out-of-range function, already owning
    set_ch(0, 2, 3); set_ch(1, 1, 0);
    req[0] = 1'b1; steps(3);
    chk("badsel_grant", 0, 32'(grant_w[0]), 32'd0);
    chk("badsel_conf", 0, 32'(conf_w[0]), 32'd0);
    req[0] = 1'b0; steps(1);
    set_ch(0, 2, 1);
    req[0] = 1'b1; steps(3);
    req[0] = 1'b0; steps(1);
    set_ch(0, 2, 0);
    req[0] = 1'b1; steps(3);
    chk("owning_grant", 0, 32'(grant_w[0]), 32'b000010);
    chk("owning_conf", 0, 32'(conf_w[0]), 32'd0);
    req[0] = 1'b0; steps(1);

    // asynchronous reset while ch0 owns f1
    #2; rst_n = 1'b0; #1;
    chk("arst_grant", 0, 32'(grant_w[0]), 32'd0);
    chk("arst_busy", 0, 32'(busy_w[0]), 32'd0);
    chk("arst_owner", 0, 32'(owner_w[0]), 32'd0);
    model_clear(); rst_cnt = 0;
    steps(2);
    rst_n = 1'b1;
    steps(4);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(15) == 0) prof[c*PW +: PW] = PW'($urandom_range(7) < 1 ? 0 : $urandom_range(3));
        if ($urandom_range(3) == 0) sel[c*SW +: SW] = SW'($urandom_range(3));
        if ($urandom_range(3) == 0) req[c] = ~req[c];
        if ($urandom_range(5) == 0) rel[c] = ~rel[c];
      end
      steps(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
